// File: rtl/seven_seg_scan_scheduler.sv
// Shared 7-segment display scan scheduler.
// Rotates enabled digits with blanking gaps, blink and decimal point.
module seven_seg_scan_scheduler #(
   parameter int NUM_DIGITS  = 4,
   parameter int BLANK_TICKS = 1
) (
   input  logic                    clock_i,
   input  logic                    reset_i,
   input  logic                    scan_tick_i,
   input  logic                    blink_tick_i,
   input  logic [4*NUM_DIGITS-1:0] digits_i,
   input  logic [NUM_DIGITS-1:0]   enable_mask_i,
   input  logic [NUM_DIGITS-1:0]   blink_mask_i,
   input  logic [NUM_DIGITS-1:0]   dp_mask_i,
   output logic [NUM_DIGITS-1:0]   anode_o,
   output logic [6:0]              cathode_o,
   output logic                    dp_o,
   output logic [2:0]              digit_idx_o,
   output logic                    frame_done_o
);

   typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

   state_t                state, state_nx;
   logic [2:0]            idx, idx_nx;
   logic [3:0]            blank_cnt, blank_cnt_nx;
   logic                  blink_phase, blink_phase_nx;
   logic [2:0]            first_idx, next_idx;
   logic                  found_first, found_next;
   logic                  show_load, frame_d, dp_bit;
   logic [NUM_DIGITS-1:0] anode_d;
   logic [3:0]            nib;
   logic [6:0]            seg_d;

   // Lowest enabled digit, and next enabled digit above idx with wrap.
   always_comb begin
      first_idx   = '0;
      next_idx    = idx;
      found_first = 1'b0;
      found_next  = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (!found_first && enable_mask_i[k]) begin
            found_first = 1'b1;
            first_idx   = 3'(k);
         end
      end
      for (int k = 1; k <= NUM_DIGITS; k++) begin
         for (int m = 0; m < NUM_DIGITS; m++) begin
            if (!found_next && enable_mask_i[m] &&
                m == (int'(idx) + k) % NUM_DIGITS) begin
               found_next = 1'b1;
               next_idx   = 3'(m);
            end
         end
      end
   end

   // State register: scan FSM, digit index, blank counter, blink phase.
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         state       <= IDLE;
         idx         <= '0;
         blank_cnt   <= '0;
         blink_phase <= 1'b0;
      end else begin
         state       <= state_nx;
         idx         <= idx_nx;
         blank_cnt   <= blank_cnt_nx;
         blink_phase <= blink_phase_nx;
      end
   end

   // Next-state logic; the FSM only moves on scan ticks.
   always_comb begin
      state_nx       = state;
      idx_nx         = idx;
      blank_cnt_nx   = blank_cnt;
      blink_phase_nx = blink_phase ^ blink_tick_i;
      if (scan_tick_i) begin
         unique case (state)
            IDLE: begin
               if (found_first) begin
                  state_nx = SHOW;
                  idx_nx   = first_idx;
               end
            end
            SHOW: begin
               if (!found_first) begin
                  state_nx = IDLE;
               end else if (BLANK_TICKS > 0) begin
                  state_nx     = BLANK;
                  blank_cnt_nx = '0;
               end else begin
                  idx_nx = next_idx;
               end
            end
            BLANK: begin
               if (!found_first) begin
                  state_nx = IDLE;
               end else if (blank_cnt == 4'(BLANK_TICKS - 1)) begin
                  state_nx = SHOW;
                  idx_nx   = next_idx;
               end else begin
                  blank_cnt_nx = blank_cnt + 4'd1;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   // Output values for the coming cycle, derived from the next state.
   always_comb begin
      show_load = scan_tick_i && (state_nx == SHOW);
      frame_d   = show_load && ((state == IDLE) || (idx_nx <= idx));
      anode_d   = '1;
      nib       = '0;
      dp_bit    = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx_nx == 3'(k)) begin
            nib    = digits_i[4*k +: 4];
            dp_bit = dp_mask_i[k];
            if (state_nx == SHOW && !(blink_phase_nx && blink_mask_i[k]))
               anode_d[k] = 1'b0;
         end
      end
      unique case (nib)
         4'h0: seg_d = 7'b1000000;
         4'h1: seg_d = 7'b1111001;
         4'h2: seg_d = 7'b0100100;
         4'h3: seg_d = 7'b0110000;
         4'h4: seg_d = 7'b0011001;
         4'h5: seg_d = 7'b0010010;
         4'h6: seg_d = 7'b0000010;
         4'h7: seg_d = 7'b1111000;
         4'h8: seg_d = 7'b0000000;
         4'h9: seg_d = 7'b0010000;
         4'hA: seg_d = 7'b0001000;
         4'hB: seg_d = 7'b0000011;
         4'hC: seg_d = 7'b1000110;
         4'hD: seg_d = 7'b0100001;
         4'hE: seg_d = 7'b0000110;
         default: seg_d = 7'b0001110;
      endcase
   end

   // Output registers; segments and dp are captured only on SHOW entry.
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         anode_o      <= '1;
         cathode_o    <= 7'h7F;
         dp_o         <= 1'b1;
         frame_done_o <= 1'b0;
      end else begin
         anode_o      <= anode_d;
         frame_done_o <= frame_d;
         if (show_load) begin
            cathode_o <= seg_d;
            dp_o      <= ~dp_bit;
         end
      end
   end

   assign digit_idx_o = idx;

endmodule

// File: tb/tb_seven_seg_scan_scheduler.sv
// Directed bench for seven_seg_scan_scheduler.
// Second instance uses zero blanking ticks.
module tb_seven_seg_scan_scheduler;

   logic        clock_i = 1'b0;
   logic        reset_i = 1'b0;
   logic        scan_tick = 1'b0;
   logic        scan_tick0 = 1'b0;
   logic        blink_tick = 1'b0;
   logic [15:0] digits = 16'h1234;
   logic [3:0]  mask = 4'h0;
   logic [3:0]  mask0 = 4'h0;
   logic [3:0]  blink_mask = 4'h0;
   logic [3:0]  dp_mask = 4'h0;

   logic [3:0]  anode, anode0;
   logic [6:0]  cathode, cathode0;
   logic        dp, dp0;
   logic [2:0]  didx, didx0;
   logic        fdone, fdone0;

   int passed = 0;
   int total  = 0;

   always #5 clock_i = ~clock_i;

   seven_seg_scan_scheduler #(.NUM_DIGITS(4), .BLANK_TICKS(1)) u_dut (
      .clock_i(clock_i), .reset_i(reset_i),
      .scan_tick_i(scan_tick), .blink_tick_i(blink_tick),
      .digits_i(digits), .enable_mask_i(mask),
      .blink_mask_i(blink_mask), .dp_mask_i(dp_mask),
      .anode_o(anode), .cathode_o(cathode), .dp_o(dp),
      .digit_idx_o(didx), .frame_done_o(fdone)
   );

   seven_seg_scan_scheduler #(.NUM_DIGITS(4), .BLANK_TICKS(0)) u_dut0 (
      .clock_i(clock_i), .reset_i(reset_i),
      .scan_tick_i(scan_tick0), .blink_tick_i(blink_tick),
      .digits_i(digits), .enable_mask_i(mask0),
      .blink_mask_i(blink_mask), .dp_mask_i(dp_mask),
      .anode_o(anode0), .cathode_o(cathode0), .dp_o(dp0),
      .digit_idx_o(didx0), .frame_done_o(fdone0)
   );

   task automatic scan_pulse();
      @(negedge clock_i); scan_tick = 1'b1;
      @(negedge clock_i); scan_tick = 1'b0;
   endtask

   task automatic scan0_pulse();
      @(negedge clock_i); scan_tick0 = 1'b1;
      @(negedge clock_i); scan_tick0 = 1'b0;
   endtask

   task automatic blink_pulse();
      @(negedge clock_i); blink_tick = 1'b1;
      @(negedge clock_i); blink_tick = 1'b0;
   endtask

   task automatic test_reset();
      reset_i = 1'b0;
      repeat (3) @(negedge clock_i);
      reset_i = 1'b1;
      repeat (100) @(negedge clock_i);
      total++;
      if (anode !== 4'hF) $display("FAIL reset_anode got %h expected %h", anode, 4'hF);
      else passed++;
      total++;
      if (cathode !== 7'h7F) $display("FAIL reset_cathode got %h expected %h", cathode, 7'h7F);
      else passed++;
      total++;
      if (dp !== 1'b1) $display("FAIL reset_dp got %b expected 1", dp);
      else passed++;
      total++;
      if (fdone !== 1'b0) $display("FAIL reset_frame_done got %b expected 0", fdone);
      else passed++;
   endtask

   task automatic test_scan_sequence();
      logic [3:0] exp_an [9] = '{4'hE, 4'hF, 4'hD, 4'hF, 4'hB, 4'hF, 4'h7, 4'hF, 4'hE};
      logic       exp_fd [9] = '{1, 0, 0, 0, 0, 0, 0, 0, 1};
      logic [6:0] exp_cat [9] = '{7'h19, 0, 7'h30, 0, 7'h24, 0, 7'h79, 0, 7'h19};
      logic       exp_dp [9] = '{1, 0, 1, 0, 0, 0, 1, 0, 1};
      mask    = 4'hF;
      digits  = 16'h1234;
      dp_mask = 4'b0100;
      for (int t = 0; t < 9; t++) begin
         scan_pulse();
         total++;
         if (anode !== exp_an[t])
            $display("FAIL seq_anode[%0d] got %b expected %b", t, anode, exp_an[t]);
         else passed++;
         total++;
         if (fdone !== exp_fd[t])
            $display("FAIL seq_frame_done[%0d] got %b expected %b", t, fdone, exp_fd[t]);
         else passed++;
         if (t % 2 == 0) begin
            total++;
            if (cathode !== exp_cat[t])
               $display("FAIL seq_cathode[%0d] got %h expected %h", t, cathode, exp_cat[t]);
            else passed++;
            total++;
            if (dp !== exp_dp[t])
               $display("FAIL seq_dp[%0d] got %b expected %b", t, dp, exp_dp[t]);
            else passed++;
            total++;
            if (didx !== 3'(t / 2 % 4))
               $display("FAIL seq_idx[%0d] got %0d expected %0d", t, didx, t / 2 % 4);
            else passed++;
         end
      end
      dp_mask = 4'h0;
   endtask

   task automatic test_data_capture();
      digits = 16'h123F;
      repeat (5) @(negedge clock_i);
      total++;
      if (cathode !== 7'h19) $display("FAIL capture_cathode got %h expected %h", cathode, 7'h19);
      else passed++;
      total++;
      if (fdone !== 1'b0) $display("FAIL capture_frame_done got %b expected 0", fdone);
      else passed++;
      digits = 16'h1234;
   endtask

   task automatic test_blink();
      blink_mask = 4'b0001;
      @(negedge clock_i);
      total++;
      if (anode !== 4'hE) $display("FAIL blink_pre got %b expected 1110", anode);
      else passed++;
      blink_pulse();
      total++;
      if (anode !== 4'hF) $display("FAIL blink_dark got %b expected 1111", anode);
      else passed++;
      blink_pulse();
      total++;
      if (anode !== 4'hE) $display("FAIL blink_restore got %b expected 1110", anode);
      else passed++;
      blink_mask = 4'b0000;
   endtask

   task automatic test_mask_clear();
      scan_pulse();
      total++;
      if (anode !== 4'hF) $display("FAIL clear_blank got %b expected 1111", anode);
      else passed++;
      mask = 4'h0;
      scan_pulse();
      total++;
      if (anode !== 4'hF) $display("FAIL clear_idle got %b expected 1111", anode);
      else passed++;
      total++;
      if (fdone !== 1'b0) $display("FAIL clear_frame_done got %b expected 0", fdone);
      else passed++;
      scan_pulse();
      total++;
      if (anode !== 4'hF) $display("FAIL clear_stay_idle got %b expected 1111", anode);
      else passed++;
      mask = 4'b1000;
      scan_pulse();
      total++;
      if (anode !== 4'h7) $display("FAIL restore_anode got %b expected 0111", anode);
      else passed++;
      total++;
      if (fdone !== 1'b1) $display("FAIL restore_frame_done got %b expected 1", fdone);
      else passed++;
      total++;
      if (didx !== 3'd3) $display("FAIL restore_idx got %0d expected 3", didx);
      else passed++;
      total++;
      if (cathode !== 7'h79) $display("FAIL restore_cathode got %h expected %h", cathode, 7'h79);
      else passed++;
   endtask

   task automatic test_skip_mask();
      logic [3:0] exp_an [6] = '{4'hE, 4'hB, 4'hE, 4'hB, 4'hE, 4'hB};
      logic       exp_fd [6] = '{1, 0, 1, 0, 1, 0};
      logic [6:0] exp_cat [6] = '{7'h19, 7'h24, 7'h19, 7'h24, 7'h19, 7'h24};
      mask0 = 4'b0101;
      for (int t = 0; t < 6; t++) begin
         scan0_pulse();
         total++;
         if (anode0 !== exp_an[t])
            $display("FAIL skip_anode[%0d] got %b expected %b", t, anode0, exp_an[t]);
         else passed++;
         total++;
         if (fdone0 !== exp_fd[t])
            $display("FAIL skip_frame_done[%0d] got %b expected %b", t, fdone0, exp_fd[t]);
         else passed++;
         total++;
         if (cathode0 !== exp_cat[t])
            $display("FAIL skip_cathode[%0d] got %h expected %h", t, cathode0, exp_cat[t]);
         else passed++;
         total++;
         if (didx0 !== 3'(2 * (t % 2)))
            $display("FAIL skip_idx[%0d] got %0d expected %0d", t, didx0, 2 * (t % 2));
         else passed++;
      end
   endtask

   task automatic test_async_reset();
      mask = 4'b0110;
      @(posedge clock_i);
      #2 reset_i = 1'b0;
      #1;
      total++;
      if (anode !== 4'hF) $display("FAIL async_anode got %b expected 1111", anode);
      else passed++;
      total++;
      if (cathode !== 7'h7F) $display("FAIL async_cathode got %h expected %h", cathode, 7'h7F);
      else passed++;
      total++;
      if (dp !== 1'b1) $display("FAIL async_dp got %b expected 1", dp);
      else passed++;
      total++;
      if (didx !== 3'd0) $display("FAIL async_idx got %0d expected 0", didx);
      else passed++;
      @(negedge clock_i);
      reset_i = 1'b1;
      @(negedge clock_i);
      scan_pulse();
      total++;
      if (anode !== 4'hD) $display("FAIL post_reset_anode got %b expected 1101", anode);
      else passed++;
      total++;
      if (fdone !== 1'b1) $display("FAIL post_reset_frame_done got %b expected 1", fdone);
      else passed++;
      total++;
      if (cathode !== 7'h30) $display("FAIL post_reset_cathode got %h expected %h", cathode, 7'h30);
      else passed++;
   endtask

   task automatic test_back_to_back();
      scan_pulse();
      total++;
      if (anode !== 4'hF) $display("FAIL b2b_blank got %b expected 1111", anode);
      else passed++;
      blink_mask = 4'b0100;
      @(negedge clock_i);
      scan_tick  = 1'b1;
      blink_tick = 1'b1;
      @(negedge clock_i);
      scan_tick  = 1'b0;
      blink_tick = 1'b0;
      total++;
      if (anode !== 4'hF) $display("FAIL b2b_anode got %b expected 1111", anode);
      else passed++;
      total++;
      if (didx !== 3'd2) $display("FAIL b2b_idx got %0d expected 2", didx);
      else passed++;
      total++;
      if (fdone !== 1'b0) $display("FAIL b2b_frame_done got %b expected 0", fdone);
      else passed++;
      total++;
      if (cathode !== 7'h24) $display("FAIL b2b_cathode got %h expected %h", cathode, 7'h24);
      else passed++;
      blink_pulse();
      total++;
      if (anode !== 4'hB) $display("FAIL b2b_unblink got %b expected 1011", anode);
      else passed++;
      blink_mask = 4'b0000;
   endtask

   initial begin
      test_reset();
      test_scan_sequence();
      test_data_capture();
      test_blink();
      test_mask_clear();
      test_skip_mask();
      test_async_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
